regfile_dump: RTL and testbench

Debug read-out engine on the opposite side of register_file's read port. On a start command it walks a range of register addresses on one read port and captures each word. It streams each word out with a valid/ready handshake to the debug/UART path. It is the reader counterpart to the writeback path that fills the register file.

---
 rtl/regfile_dump_pkg.sv | 28 ++
 rtl/regfile_dump.sv | 134 +++++++++++++
 tb/tb_regfile_dump.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared constants and FSM encoding for the register-file dump engine.
// Build option: REGFILE_DUMP_CHECKSUM_EN adds a trailing checksum word (CSUM state).
package regfile_dump_pkg;

  localparam int DUMP_ADRS_W = 5;
  localparam int DUMP_WORD_W = 32;
  localparam int N_REGS      = 1 << DUMP_ADRS_W;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int STATE_W = 3;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_DONE  = 3'd3,
    ST_CSUM  = 3'd4
  } dump_state_e;
`else
  localparam int STATE_W = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;
`endif

endpackage

// File: rtl/regfile_dump.sv
// Walks a register range on one register_file read port and streams each word out.
// Build option: REGFILE_DUMP_CHECKSUM_EN appends a running-sum word after the last register.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADRS_W = DUMP_ADRS_W,
  parameter int WORD_W = DUMP_WORD_W
) (
  input  logic               clk_cpu,
  input  logic               reset,
  input  logic               start,
  input  logic [ADRS_W-1:0]  start_adrs,
  input  logic [ADRS_W-1:0]  end_adrs,
  output logic [ADRS_W-1:0]  rd_adrs,
  input  logic [WORD_W-1:0]  rd_data,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [WORD_W-1:0]  dout_data,
  output logic [ADRS_W-1:0]  dout_adrs,
  output logic               dout_last,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] dbg_state
);

  // Handshake: a word transfers on a posedge where dout_valid && dout_ready;
  // while dout_valid && !dout_ready every dout_* output holds its value.

  dump_state_e       state;
  logic [ADRS_W-1:0] cur;
  logic [ADRS_W-1:0] end_r;
  logic [ADRS_W-1:0] nxt_adrs;
  logic              at_end;

  assign nxt_adrs  = cur + ADRS_W'(1);
  assign at_end    = (cur == end_r);
  assign dbg_state = state;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] sum_nxt;
  assign sum_nxt = sum + dout_data;
`endif

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cur        <= '0;
      end_r      <= '0;
      rd_adrs    <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_adrs  <= '0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur     <= start_adrs;
            end_r   <= end_adrs;
            rd_adrs <= start_adrs;
            busy    <= 1'b1;
            state   <= ST_FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            sum     <= '0;
`endif
          end
        end
        ST_FETCH: begin
          dout_data  <= rd_data;
          dout_adrs  <= cur;
          dout_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          dout_last  <= 1'b0;
`else
          dout_last  <= at_end;
`endif
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            if (at_end) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Checksum word goes out next cycle, folding in the word just accepted.
              sum        <= sum_nxt;
              dout_data  <= sum_nxt;
              dout_adrs  <= '0;
              dout_last  <= 1'b1;
              dout_valid <= 1'b1;
              state      <= ST_CSUM;
`else
              dout_last  <= 1'b0;
              done       <= 1'b1;
              state      <= ST_DONE;
`endif
            end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              sum     <= sum_nxt;
`endif
              cur     <= nxt_adrs;
              rd_adrs <= nxt_adrs;
              state   <= ST_FETCH;
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file and an expected-word scoreboard.
// Honours REGFILE_DUMP_CHECKSUM_EN when compiled with it.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int AW    = DUMP_ADRS_W;
  localparam int DW    = DUMP_WORD_W;
  localparam int EXP_W = 1 + AW + DW;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  logic               reset;
  logic               start;
  logic [AW-1:0]      start_adrs;
  logic [AW-1:0]      end_adrs;
  logic [AW-1:0]      rd_adrs;
  logic [DW-1:0]      rd_data;
  logic               dout_valid;
  logic               dout_ready;
  logic [DW-1:0]      dout_data;
  logic [AW-1:0]      dout_adrs;
  logic               dout_last;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] dbg_state;

  // Behavioural register file: combinational read port A
  logic [DW-1:0] regs [N_REGS];
  assign rd_data = regs[rd_adrs];

  regfile_dump dut (
    .clk_cpu    (clk_cpu),
    .reset      (reset),
    .start      (start),
    .start_adrs (start_adrs),
    .end_adrs   (end_adrs),
    .rd_adrs    (rd_adrs),
    .rd_data    (rd_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_adrs  (dout_adrs),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [EXP_W-1:0] held;
  logic [EXP_W-1:0] got;
  bit               stalled = 0;

  always @(negedge clk_cpu) begin
    if (!reset) begin
      stalled = 0;
    end else if (dout_valid) begin
      got = {dout_last, dout_adrs, dout_data};
      if (stalled) check("stall_hold", 64'(got), 64'(held));
      if (dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", got, $time);
        end else begin
          check("word", 64'(got), 64'(exp_q.pop_front()));
        end
        n_hs++;
        stalled = 0;
      end else begin
        held    = got;
        stalled = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic push_dump(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a;
    logic [DW-1:0] sum;
    a   = s;
    sum = '0;
    for (int n = 0; n < N_REGS; n++) begin
      sum = sum + regs[a];
      exp_q.push_back({(CS == 0) && (a == e), a, regs[a]});
      if (a == e) break;
      a = a + AW'(1);
    end
    if (CS != 0) exp_q.push_back({1'b1, AW'(0), sum});
  endtask

  task automatic run_dump(input string name, input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input int exp_busy, input bit poke_done);
    int cnt;
    int done_cnt;
    start_adrs = s;
    end_adrs   = e;
    start      = 1'b1;
    step();
    start      = 1'b0;
    cnt        = 0;
    done_cnt   = 0;
    while (busy && cnt < 300) begin
      cnt++;
      if (done) begin
        done_cnt++;
        if (poke_done) begin
          start_adrs = 5'd9;
          end_adrs   = 5'd9;
          start      = 1'b1;
          step();
          start      = 1'b0;
        end else begin
          step();
        end
      end else begin
        step();
      end
    end
    check({name, "_busy_timeout"}, 64'(busy), 64'(0));
    check({name, "_done_pulses"}, 64'(done_cnt), 64'(1));
    if (exp_busy >= 0) check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
    for (int i = 0; i < 3; i++) begin
      step();
      check({name, "_idle_after"}, 64'({busy, dout_valid, done}), 64'(0));
    end
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic stall_word2();
    int cnt;
    cnt = 0;
    while (!(dout_valid && dout_adrs == 5'd2) && cnt < 50) begin
      step();
      cnt++;
    end
    check("stall_found_word2", 64'(cnt < 50), 64'(1));
    dout_ready = 1'b0;
    repeat (7) step();
    dout_ready = 1'b1;
  endtask

  task automatic poke_start_busy();
    repeat (3) step();
    start_adrs = 5'd7;
    end_adrs   = 5'd9;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    reset      = 1'b0;
    start      = 1'b0;
    start_adrs = '0;
    end_adrs   = '0;
    dout_ready = 1'b1;
    for (int i = 0; i < N_REGS; i++) regs[i] = 32'hA500_0000 + 32'(i);
    #1;
    check("reset_outputs", 64'({rd_adrs, dout_valid, dout_data, dout_adrs, dout_last, busy, done}), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(0));
    step();
    step();
    reset = 1'b1;
    step();

    // Full range, ready held high
    push_dump(5'd0, 5'd31);
    run_dump("full", 5'd0, 5'd31, 65 + CS, 1'b0);

    // Single word, plus a start pulse during the DONE cycle
    push_dump(5'd5, 5'd5);
    run_dump("single", 5'd5, 5'd5, 3 + CS, 1'b1);

    // Wrapping range 30..1 with an ignored start while busy
    push_dump(5'd30, 5'd1);
    fork
      run_dump("wrap", 5'd30, 5'd1, 9 + CS, 1'b0);
      poke_start_busy();
    join

    // Stall on word 2
    push_dump(5'd0, 5'd3);
    fork
      run_dump("stall", 5'd0, 5'd3, -1, 1'b0);
      stall_word2();
    join

    // Reset in the middle of a full dump
    push_dump(5'd0, 5'd31);
    n_hs       = 0;
    start_adrs = 5'd0;
    end_adrs   = 5'd31;
    start      = 1'b1;
    step();
    start      = 1'b0;
    cnt        = 0;
    while (n_hs < 10 && cnt < 100) begin
      step();
      cnt++;
    end
    check("midreset_reached_word10", 64'(n_hs), 64'(10));
    reset = 1'b0;
    #1;
    check("midreset_outputs", 64'({rd_adrs, dout_valid, dout_data, dout_adrs, dout_last, busy, done}), 64'(0));
    check("midreset_state", 64'(dbg_state), 64'(0));
    exp_q.delete();
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_reset_quiet", 64'({busy, dout_valid}), 64'(0));
    end
    push_dump(5'd0, 5'd0);
    run_dump("after_reset", 5'd0, 5'd0, 3 + CS, 1'b0);

    // Small known values: plain dump or checksum dump
    for (int i = 0; i < 4; i++) regs[i] = 32'(i + 1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    exp_q.push_back({1'b0, 5'd0, 32'h1});
    exp_q.push_back({1'b0, 5'd1, 32'h2});
    exp_q.push_back({1'b0, 5'd2, 32'h3});
    exp_q.push_back({1'b0, 5'd3, 32'h4});
    exp_q.push_back({1'b1, 5'd0, 32'hA});
    fork
      run_dump("csum", 5'd0, 5'd3, 10, 1'b0);
      poke_start_busy();
    join
`else
    exp_q.push_back({1'b0, 5'd0, 32'h1});
    exp_q.push_back({1'b0, 5'd1, 32'h2});
    exp_q.push_back({1'b0, 5'd2, 32'h3});
    exp_q.push_back({1'b1, 5'd3, 32'h4});
    fork
      run_dump("small", 5'd0, 5'd3, 9, 1'b0);
      poke_start_busy();
    join
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
